// File: rtl/booth_ctrl_pkg.sv
// Shared types and default sizing for the Booth multiplier arbiter.
package booth_ctrl_pkg;

  localparam int NREQ_DFLT    = 4;
  localparam int WIDTH_DFLT   = 521;
  localparam int TIMEOUT_DFLT = 1100;

  localparam int ID_W = $clog2(NREQ_DFLT);
  localparam int WD_W = $clog2(TIMEOUT_DFLT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/booth_mul_arbiter_rr_arbiter.sv
// Combinational round-robin select: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   idx,
  output logic            found
);

  always_comb begin
    int unsigned j;
    logic [IW-1:0] sel;
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    sel   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      j   = (32'(ptr) + k) % NREQ;
      sel = IW'(j);
      if (!found && req[sel]) begin
        found      = 1'b1;
        grant[sel] = 1'b1;
        idx        = sel;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin sharing of one multi-cycle Booth multiplier core, with a
// watchdog that turns a missing mul_done into an error response.
module booth_mul_arbiter
  import booth_ctrl_pkg::*;
#(
  parameter int NREQ    = NREQ_DFLT,
  parameter int WIDTH   = WIDTH_DFLT,
  parameter int TIMEOUT = TIMEOUT_DFLT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*WIDTH-1:0]     req_a,
  input  logic [NREQ*WIDTH-1:0]     req_b,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]        rsp_c,
  output logic                      rsp_err,
  output logic                      mul_start,
  output logic [WIDTH-1:0]          mul_a,
  output logic [WIDTH-1:0]          mul_b,
  input  logic                      mul_done,
  input  logic [2*WIDTH-1:0]        mul_c,
  output logic                      busy
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, cur_id, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            gnt_any;
  logic [CW-1:0]   wd_cnt;
  logic            wd_expired;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx),
    .found (gnt_any)
  );

  assign wd_expired = (wd_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (mul_done || wd_expired) state_nx = RESP;
      RESP:    if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Done is tested before the watchdog so a coincident done still wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      cur_id  <= '0;
      wd_cnt  <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      rsp_c   <= '0;
      rsp_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (gnt_any) begin
          mul_a  <= req_a[gnt_idx*WIDTH +: WIDTH];
          mul_b  <= req_b[gnt_idx*WIDTH +: WIDTH];
          cur_id <= gnt_idx;
        end
        ISSUE: wd_cnt <= '0;
        WAIT: begin
          if (mul_done) begin
            rsp_c   <= mul_c;
            rsp_err <= 1'b0;
          end else if (wd_expired) begin
            rsp_c   <= '0;
            rsp_err <= 1'b1;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
        end
        RESP: if (rsp_ready) begin
          rr_ptr <= (cur_id == IW'(NREQ - 1)) ? '0 : cur_id + IW'(1);
        end
        default: ;
      endcase
    end
  end

  assign req_ready = (state == IDLE) ? gnt : '0;
  assign mul_start = (state == ISSUE);
  assign rsp_valid = (state == RESP);
  assign rsp_id    = (state == RESP) ? cur_id : '0;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench for booth_mul_arbiter with a 523-cycle behavioural core.
module tb_booth_mul_arbiter;
  import booth_ctrl_pkg::*;

  localparam int N  = NREQ_DFLT;
  localparam int W  = WIDTH_DFLT;
  localparam int TO = TIMEOUT_DFLT;
  localparam int P  = 2 * W;
  localparam int L  = 523;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [N*W-1:0]    req_a, req_b;
  logic              rsp_valid, rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [P-1:0]      rsp_c;
  logic              rsp_err;
  logic              mul_start;
  logic [W-1:0]      mul_a, mul_b;
  logic              mul_done = 1'b0;
  logic [P-1:0]      mul_c = '0;
  logic              busy;

  booth_mul_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_c(rsp_c), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_c(mul_c), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural core: done pulses L cycles after the start cycle.
  logic              hang = 1'b0;
  logic              mpend = 1'b0;
  int unsigned       mcnt = 0;
  logic signed [P-1:0] mprod;

  always @(posedge clk) begin
    if (rst) begin
      mpend = 1'b0;
      mul_done <= 1'b0;
    end else if (mul_start && !hang) begin
      mpend = 1'b1;
      mcnt  = 1;
      mprod = $signed(mul_a) * $signed(mul_b);
      mul_done <= 1'b0;
    end else if (mpend) begin
      mcnt++;
      if (mcnt == L) begin
        mul_done <= 1'b1;
        mul_c    <= mprod;
        mpend = 1'b0;
      end else begin
        mul_done <= 1'b0;
      end
    end else begin
      mul_done <= 1'b0;
    end
  end

  int vecs = 0;
  int errs = 0;

  task automatic check(input string tag, input logic [P-1:0] got, input logic [P-1:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h..%h expected %h..%h", tag,
               got[P-1 -: 64], got[63:0], exp[P-1 -: 64], exp[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      #1;
      if (req_ready[i]) break;
      tick();
    end
    check("grant", P'(req_ready[i]), P'(1));
    tick();
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    while (!rsp_valid && n < 3000) begin
      tick();
      n++;
    end
    check("rsp_seen", P'(rsp_valid), P'(1));
  endtask

  int n;
  int bad;
  logic [P-1:0] e;
  logic [P-1:0] hold_c;

  initial begin
    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (3) tick();
    check("rst_rsp_valid", P'(rsp_valid), '0);
    check("rst_busy", P'(busy), '0);
    check("rst_mul_start", P'(mul_start), '0);
    check("rst_mul_a", P'(mul_a), '0);
    check("rst_rsp_c", rsp_c, '0);
    check("rst_rsp_err", P'(rsp_err), '0);
    rst = 1'b0;

    // 1) single request, latency
    rsp_ready = 1'b1;
    issue(0, W'(3), W'(-5));
    wait_rsp(n);
    check("t1_latency", P'(n), P'(524));
    check("t1_id", P'(rsp_id), P'(0));
    check("t1_c", rsp_c, -15);
    check("t1_err", P'(rsp_err), '0);
    tick();
    check("t1_resp_one_cycle", P'(rsp_valid), '0);
    check("t1_idle", P'(busy), '0);

    // 2) all valid from reset, round-robin order with wrap
    rst = 1'b1;
    tick();
    for (int i = 0; i < N; i++) begin
      req_a[i*W +: W] = W'(i + 1);
      req_b[i*W +: W] = W'(7);
    end
    req_valid = '1;
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(n);
      check("t2_id", P'(rsp_id), P'(k % N));
      check("t2_c", rsp_c, P'((k % N + 1) * 7));
      if (k == 4) req_valid = '0;
      tick();
    end

    // 3) extremes
    issue(1, {1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}});
    wait_rsp(n);
    e = '0; e[P-2] = 1'b1;
    check("t3_min_sq", rsp_c, e);
    tick();
    issue(1, {1'b0, {(W-1){1'b1}}}, '1);
    wait_rsp(n);
    e = {{(P-W+1){1'b0}}, {(W-1){1'b1}}};
    e = ~e + 1'b1;
    check("t3_max_neg1", rsp_c, e);
    tick();

    // 4) watchdog abort, then normal completion
    hang = 1'b1;
    issue(3, W'(5), W'(5));
    wait_rsp(n);
    check("t4_abort_time", P'(n), P'(TO + 1));
    check("t4_err", P'(rsp_err), P'(1));
    check("t4_c", rsp_c, '0);
    check("t4_id", P'(rsp_id), P'(3));
    tick();
    hang = 1'b0;
    issue(0, W'(-4), W'(6));
    wait_rsp(n);
    check("t4_next_c", rsp_c, -24);
    check("t4_next_err", P'(rsp_err), '0);
    tick();

    // 5) backpressure
    rsp_ready = 1'b0;
    issue(2, W'(9), W'(-9));
    req_a[1*W +: W] = W'(2);
    req_b[1*W +: W] = W'(3);
    req_valid[1] = 1'b1;
    wait_rsp(n);
    check("t5_c", rsp_c, -81);
    check("t5_id", P'(rsp_id), P'(2));
    hold_c = rsp_c;
    bad = 0;
    repeat (50) begin
      tick();
      if (!rsp_valid || rsp_c !== hold_c || rsp_id !== 2'd2 || rsp_err !== 1'b0 ||
          req_ready !== '0 || busy !== 1'b1) bad++;
    end
    check("t5_hold", P'(bad), '0);
    rsp_ready = 1'b1;
    tick();
    check("t5_next_grant", P'(req_ready), P'(4'b0010));
    tick();
    req_valid[1] = 1'b0;
    wait_rsp(n);
    check("t5_next_c", rsp_c, P'(6));
    check("t5_next_id", P'(rsp_id), P'(1));
    tick();

    // 6) reset during WAIT
    issue(1, W'(11), W'(11));
    repeat (100) tick();
    rst = 1'b1;
    tick();
    check("t6_rsp_valid", P'(rsp_valid), '0);
    check("t6_busy", P'(busy), '0);
    check("t6_mul_a", P'(mul_a), '0);
    check("t6_mul_b", P'(mul_b), '0);
    check("t6_rsp_c", rsp_c, '0);
    check("t6_rsp_id", P'(rsp_id), '0);
    rst = 1'b0;
    bad = 0;
    repeat (600) begin
      tick();
      if (rsp_valid || busy || mul_start) bad++;
    end
    check("t6_no_rsp", P'(bad), '0);
    req_a[1*W +: W] = W'(1);  req_b[1*W +: W] = W'(1);
    req_a[2*W +: W] = W'(-7); req_b[2*W +: W] = W'(8);
    req_valid = 4'b0110;
    #1;
    check("t6_ptr_zero", P'(req_ready), P'(4'b0010));
    req_valid[1] = 1'b0;
    #1;
    check("t6_drop_before_grant", P'(req_ready), P'(4'b0100));
    tick();
    req_valid = '0;
    wait_rsp(n);
    check("t6_id", P'(rsp_id), P'(2));
    check("t6_c", rsp_c, -56);
    check("t6_err", P'(rsp_err), '0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
